serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and ND = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin, 1 = A-B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port carry, output, 1 bit: carry out of MSB; for sub, 1 = no borrow.
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL be in IDLE after reset.
REQ-016 A start sampled high in IDLE or DONE SHALL be accepted: latch a, b, sub and cin; clear the digit counter; go to RUN.
REQ-017 In IDLE or DONE with start low, the block SHALL go to (or stay in) IDLE.
REQ-018 In RUN, on each edge the block SHALL add digit i of A and digit i of B' plus the stored carry, write sum digit i, store the digit carry-out, and increment i, starting from the LSB digit (i=0).
REQ-019 B' SHALL equal ~B when sub=1 and B when sub=0; the initial carry SHALL equal 1 when sub=1 and cin when sub=0.
REQ-020 After the edge processing digit ND-1, the block SHALL register carry and overflow and go to DONE.
REQ-021 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 Latency: with start accepted at edge 0, done SHALL be high for exactly the cycle following edge ND, i.e. ND+1 edges from request to result.
REQ-023 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-024 start while in RUN SHALL be ignored, with no effect on the operands or the result.
REQ-025 sum, carry and overflow SHALL be held stable from DONE until the next accepted start.
REQ-026 Back-to-back: a start accepted in DONE SHALL begin a new operation with no idle cycle between.
REQ-027 During RUN, sum SHALL be undefined to observers; only the value present while done=1 is specified.
REQ-028 With DIGIT=WIDTH (ND=1), the block SHALL complete in one RUN cycle and obey every other rule above.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH with no saturation.

Reset
REQ-030 rst_n low SHALL immediately force the FSM to IDLE, with busy=0, done=0, sum=0, carry=0, overflow=0, digit counter=0 and stored carry=0.
REQ-031 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as after power-up.
REQ-032 Deassertion of rst_n is synchronised externally; the block SHALL require no internal reset synchroniser.

Structure
REQ-033 Package serial_adder_pkg SHALL hold the state encoding (IDLE, RUN, DONE) and the ND derivation function.
REQ-034 Sub-module digit_adder SHALL be a combinational DIGIT-bit ripple adder built from full-adder cells, exporting sum, carry-out and carry into its MSB.
REQ-035 A single instance of digit_adder SHALL be used, time-multiplexed over the digits.
REQ-036 The block SHALL contain no other hierarchy.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-037 The bench SHALL check: a=0x00FF, b=0x0001, sub=0, cin=0 -> sum=0x0100, carry=0, overflow=0, with done high exactly 5 edges after the start edge.
REQ-038 The bench SHALL check: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry=1, overflow=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1.
REQ-039 The bench SHALL check: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1, overflow=1; and a=0x0001, b=0x0002, sub=1 -> sum=0xFFFF, carry=0.
REQ-040 The bench SHALL check that start pulses at RUN cycles 1 and 3 with different operands are ignored, so the result still matches the first operands; and that start in DONE yields a second done exactly 5 edges later.
REQ-041 The bench SHALL check that rst_n pulsed low during RUN cycle 2 gives all outputs 0 immediately and no done pulse, and that the next operation returns a correct result.
REQ-042 The bench SHALL check, with DIGIT=16: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, with done on the 2nd edge after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that derive the digit count and digit-index width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nd_of(input int width, input int digit);
    return width / digit;
  endfunction

  // Index register width; a single-digit adder still needs one bit.
  function automatic int idx_bits(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder from full-adder cells. Exports the
// carry into the MSB so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co    = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide ripple adder reused over
// WIDTH/DIGIT cycles, LSB digit first, with carry/overflow registered at the end.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one digit processed per clock, busy=1
// DONE  | result valid for one cycle, done=1; start here re-launches
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int ND = nd_of(WIDTH, DIGIT);
  localparam int CW = idx_bits(ND);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;
  logic [CW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  assign w_last = (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .i_a     (r_a[int'(r_idx) * DIGIT +: DIGIT]),
    .i_b     (r_b[int'(r_idx) * DIGIT +: DIGIT]),
    .i_ci    (r_c),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_cmsb)
  );

  // B is stored pre-inverted for subtract so RUN is always a plain add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_c   <= sub | cin;
      r_idx <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx) * DIGIT +: DIGIT] <= w_s;
      r_c   <= w_co;
      r_idx <= w_last ? '0 : r_idx + CW'(1);
      if (w_last) begin
        r_carry <= w_co;
        r_ovf   <= w_co ^ w_cmsb;
      end
    end
  end

  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a 4-bit-digit instance for the main
// cases and a single-digit instance for the one-cycle configuration.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_w = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;

  logic        busy, done, carry, overflow;
  logic [15:0] sum;
  logic        busy_w, done_w, carry_w, overflow_w;
  logic [15:0] sum_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy_w), .done(done_w), .sum(sum_w), .carry(carry_w), .overflow(overflow_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns just after the sampling edge (counted as edge 1).
  task automatic launch(input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin);
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin, input logic [15:0] esum,
                        input logic ecar, input logic eovf);
    int n;
    launch(ia, ib, isub, icin);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'd5);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_carry"}, 32'(carry), 32'(ecar));
    check({tag, "_ovf"}, 32'(overflow), 32'(eovf));
  endtask

  initial begin
    int n;
    int done_seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done_pulse_len", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", 32'(sum), 32'h0100);

    run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
    run_op("sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("sub_cin_ignored", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Mid-RUN reset after a result with sum, carry and overflow all nonzero.
    launch(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    run_op("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Starts during RUN cycles 1 and 3 carry different operands and must be ignored.
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum", 32'(sum), 32'h3333);
    check("ign_carry", 32'(carry), 32'd0);

    // Back-to-back start issued while done is high.
    a = 16'h0F0F; b = 16'h00F1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_lat", 32'(n), 32'd5);
    check("b2b_sum", 32'(sum), 32'h1000);

    // Single-digit instance: result on the second edge counting the sampling edge.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b1; start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    check("nd1_busy", 32'(busy_w), 32'd1);
    n = 1;
    while (!done_w && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("nd1_lat", 32'(n), 32'd2);
    check("nd1_sum", 32'(sum_w), 32'h5556);
    check("nd1_carry", 32'(carry_w), 32'd0);
    @(posedge clk); #1;
    check("nd1_done_len", 32'(done_w), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
